write_back: RTL and testbench
=============================

// Module: write_back
// PURPOSE
//  Final core stage, directly downstream of the execute stage. Consumes the execute result
//  (wselector/data/pc_out/rd_out/done) and commits it to architectural state:
//  - 32x32 integer register file
//  - 32x32 float register file
//  - program counter
//  - retired-instruction counter
//  Provides combinational register reads to decode and the committed PC to fetch.
// PARAMETERS
//  RESET_PC  32'h0  PC value loaded at reset
//  PC_STEP   32'h4  PC increment when no branch/jump is committed
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  rst        in   1   reset, asynchronous, active-high
//  enable     in   1   commit strobe (execute done), single-cycle pulse per instruction
//  wselector  in   3   [2]=PC write, [1]=register write, [0]=float file select
//  data       in   32  value written to the register file
//  pc_target  in   32  branch/jump target (execute pc_out)
//  rd         in   5   destination register index (execute rd_out)
//  rs_idx     in   5   integer read port A index
//  rt_idx     in   5   integer read port B index
//  fs_idx     in   5   float read port A index
//  ft_idx     in   5   float read port B index
//  rs_val     out  32  integer file [rs_idx], combinational
//  rt_val     out  32  integer file [rt_idx], combinational
//  fs_val     out  32  float file [fs_idx], combinational
//  ft_val     out  32  float file [ft_idx], combinational
//  pc         out  32  committed PC = address of next instruction to fetch
//  done       out  1   one-cycle pulse, cycle after enable; pc/registers already updated
//  instret    out  32  count of committed instructions
// BEHAVIOUR
//  Reset (async, immediate on rst=1, independent of clk):
//  - pc=RESET_PC, done=0, instret=0, all 64 registers=0.
//  Commit (rising edge with enable=1), all updates in the same edge:
//  - wselector[1]=1, [0]=0: int[rd] <= data, except rd==0 (int r0 hardwired 0, write dropped).
//  - wselector[1]=1, [0]=1: flt[rd] <= data; f0 is writable.
//  - wselector[2]=1: pc <= {pc_target[31:2],2'b00}.
//  - wselector[2]=0: pc <= pc + PC_STEP, mod 2^32 (wraps 32'hfffffffc -> 32'h0).
//  - instret <= instret+1, mod 2^32.
//  - done <= 1.
//  No commit (enable=0): state held, done <= 0.
//  Decode rule, no illegal codes: every 3-bit wselector is decoded by these bit rules.
//  - 000: PC step only.
//  - 101: PC write, no register write.
//  - 111: PC write + float write.
//  Latency:
//  - done rises exactly 1 cycle after enable.
//  - back-to-back enables on consecutive cycles are legal; each commits; done stays high.
//  Reads:
//  - asynchronous array reads, no write-through bypass.
//  - same-cycle read of rd returns the old value until the commit edge, new value after it.
//  - rs_val/rt_val are 0 whenever the index is 0.
//  Reset mid-operation: an enable coincident with rst is discarded; no partial commit.
// TESTING
//  T1 reset: rst=1 mid-run -> pc=RESET_PC, done=0, instret=0, rs_val=0 for all indices,
//     without waiting for a clock edge.
//  T2 ALU: enable, wselector=010, rd=5, data=32'hdeadbeef -> next cycle rs_idx=5 reads
//     deadbeef, pc=4, done=1 for 1 cycle, instret=1.
//  T3 r0 vs f0: wselector=010, rd=0, data=7 -> rs_val[0]=0;
//     wselector=011, rd=0, data=7 -> fs_val[0]=7.
//  T4 JAL link: pc=32'h100, wselector=110, rd=31, data=32'h104, pc_target=32'h203
//     -> pc=32'h200, int[31]=104.
//  T5 back-to-back: three enables on consecutive cycles, wselector=000 from pc=32'hfffffff8
//     -> pc sequence fffffffc, 0, 4; done high 3 cycles; instret=3.
//  T6 read-during-write: rd=rs_idx=9, data=1 with old int[9]=0 -> rs_val=0 in the commit
//     cycle, 1 after.

Source files
------------

// File: rtl/write_back_if.sv
// Commit bus from execute plus register/PC read ports toward decode and fetch.
// Latency: n/a (signal bundle only).
// Backpressure: none; enable is a single-cycle strobe and always accepted.
interface write_back_if;
    logic        enable;
    logic [2:0]  wselector;
    logic [31:0] data;
    logic [31:0] pc_target;
    logic [4:0]  rd;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [4:0]  fs_idx;
    logic [4:0]  ft_idx;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] fs_val;
    logic [31:0] ft_val;
    logic [31:0] pc;
    logic        done;
    logic [31:0] instret;

    // Execute/decode/fetch side: drives commit and read indices, observes state.
    modport master (
        output enable, wselector, data, pc_target, rd,
        output rs_idx, rt_idx, fs_idx, ft_idx,
        input  rs_val, rt_val, fs_val, ft_val, pc, done, instret
    );

    // Write-back side: owns architectural state.
    modport slave (
        input  enable, wselector, data, pc_target, rd,
        input  rs_idx, rt_idx, fs_idx, ft_idx,
        output rs_val, rt_val, fs_val, ft_val, pc, done, instret
    );
endinterface

// File: rtl/write_back.sv
// Final stage: commits execute results to int/float register files, PC and retired count.
// Latency: state updates on the enable edge; done pulses the cycle after enable; reads are combinational.
// Backpressure: none; every enable commits, back-to-back enables are accepted each cycle.
module write_back #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] PC_STEP  = 32'h4
) (
    input  logic         clk,
    input  logic         rst,
    write_back_if.slave  bus
);

    logic [31:0] int_rf_q [32];
    logic [31:0] flt_rf_q [32];
    logic [31:0] pc_q, pc_d;
    logic [31:0] instret_q, instret_d;
    logic        done_q, done_d;
    logic        int_we, flt_we;
    logic [31:0] pc_tgt_aligned;

    // Decode the write selector; r0 writes are dropped so it always reads zero.
    always_comb begin
        int_we         = bus.enable & bus.wselector[1] & ~bus.wselector[0] & (bus.rd != 5'd0);
        flt_we         = bus.enable & bus.wselector[1] &  bus.wselector[0];
        pc_tgt_aligned = bus.pc_target & ~32'h3;
    end

    // Next-state for PC, retired counter and done pulse.
    always_comb begin
        pc_d      = pc_q;
        instret_d = instret_q;
        done_d    = bus.enable;
        if (bus.enable) begin
            pc_d      = bus.wselector[2] ? pc_tgt_aligned : pc_q + PC_STEP;
            instret_d = instret_q + 32'd1;
        end
    end

    // PC / instret / done registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            instret_q <= '0;
            done_q    <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            instret_q <= instret_d;
            done_q    <= done_d;
        end
    end

    // Integer register file write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) int_rf_q[i] <= '0;
        end else if (int_we) begin
            int_rf_q[bus.rd] <= bus.data;
        end
    end

    // Float register file write port; f0 is an ordinary register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) flt_rf_q[i] <= '0;
        end else if (flt_we) begin
            flt_rf_q[bus.rd] <= bus.data;
        end
    end

    // Combinational reads, no bypass: a same-cycle write shows up only after the edge.
    always_comb begin
        bus.rs_val  = (bus.rs_idx == 5'd0) ? 32'd0 : int_rf_q[bus.rs_idx];
        bus.rt_val  = (bus.rt_idx == 5'd0) ? 32'd0 : int_rf_q[bus.rt_idx];
        bus.fs_val  = flt_rf_q[bus.fs_idx];
        bus.ft_val  = flt_rf_q[bus.ft_idx];
        bus.pc      = pc_q;
        bus.done    = done_q;
        bus.instret = instret_q;
    end

endmodule

// File: tb/tb_write_back.sv
module tb_write_back;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] exp_instret;

    write_back_if bus ();

    write_back #(.RESET_PC(32'h0), .PC_STEP(32'h4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.enable    = 1'b0;
        bus.wselector = 3'b000;
        bus.data      = 32'h0;
        bus.pc_target = 32'h0;
        bus.rd        = 5'd0;
        bus.rs_idx    = 5'd0;
        bus.rt_idx    = 5'd0;
        bus.fs_idx    = 5'd0;
        bus.ft_idx    = 5'd0;
    endtask

    // Drive one commit between two falling edges; returns at the falling edge after the commit.
    task automatic commit(input logic [2:0] ws, input logic [4:0] rd, input logic [31:0] dat,
                          input logic [31:0] tgt);
        @(negedge clk);
        bus.enable    = 1'b1;
        bus.wselector = ws;
        bus.rd        = rd;
        bus.data      = dat;
        bus.pc_target = tgt;
        @(negedge clk);
        bus.enable    = 1'b0;
        exp_instret   = exp_instret + 32'd1;
    endtask

    task automatic test_reset();
        n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want %h", bus.pc, 32'h0); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_checks++; if (bus.instret !== 32'h0) begin n_fail++; $display("FAIL reset_instret got %h want 0", bus.instret); end
        @(negedge clk);
        rst = 1'b0;
        exp_instret = 32'h0;
    endtask

    task automatic test_alu();
        commit(3'b010, 5'd5, 32'hdeadbeef, 32'h0);
        bus.rs_idx = 5'd5;
        bus.rt_idx = 5'd5;
        #1;
        n_checks++; if (bus.rs_val !== 32'hdeadbeef) begin n_fail++; $display("FAIL alu_rs got %h want deadbeef", bus.rs_val); end
        n_checks++; if (bus.rt_val !== 32'hdeadbeef) begin n_fail++; $display("FAIL alu_rt got %h want deadbeef", bus.rt_val); end
        n_checks++; if (bus.pc !== 32'h4) begin n_fail++; $display("FAIL alu_pc got %h want 4", bus.pc); end
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL alu_done got %b want 1", bus.done); end
        n_checks++; if (bus.instret !== 32'h1) begin n_fail++; $display("FAIL alu_instret got %h want 1", bus.instret); end
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL alu_done_drop got %b want 0", bus.done); end
    endtask

    task automatic test_r0_f0();
        commit(3'b010, 5'd0, 32'h7, 32'h0);
        bus.rs_idx = 5'd0;
        #1;
        n_checks++; if (bus.rs_val !== 32'h0) begin n_fail++; $display("FAIL r0_hardwired got %h want 0", bus.rs_val); end
        commit(3'b011, 5'd0, 32'h7, 32'h0);
        bus.fs_idx = 5'd0;
        bus.ft_idx = 5'd0;
        bus.rs_idx = 5'd5;
        #1;
        n_checks++; if (bus.fs_val !== 32'h7) begin n_fail++; $display("FAIL f0_write got %h want 7", bus.fs_val); end
        n_checks++; if (bus.ft_val !== 32'h7) begin n_fail++; $display("FAIL f0_write_ft got %h want 7", bus.ft_val); end
        n_checks++; if (bus.rs_val !== 32'hdeadbeef) begin n_fail++; $display("FAIL float_no_int_write got %h want deadbeef", bus.rs_val); end
        n_checks++; if (bus.pc !== 32'hc) begin n_fail++; $display("FAIL r0f0_pc got %h want c", bus.pc); end
    endtask

    task automatic test_jal();
        commit(3'b100, 5'd3, 32'h55, 32'h100);
        #1;
        n_checks++; if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL jump_pc got %h want 100", bus.pc); end
        bus.rs_idx = 5'd3;
        #1;
        n_checks++; if (bus.rs_val !== 32'h0) begin n_fail++; $display("FAIL jump_no_regwrite got %h want 0", bus.rs_val); end
        commit(3'b110, 5'd31, 32'h104, 32'h203);
        bus.rs_idx = 5'd31;
        #1;
        n_checks++; if (bus.pc !== 32'h200) begin n_fail++; $display("FAIL jal_pc got %h want 200", bus.pc); end
        n_checks++; if (bus.rs_val !== 32'h104) begin n_fail++; $display("FAIL jal_link got %h want 104", bus.rs_val); end
        commit(3'b111, 5'd4, 32'h3f800000, 32'h300);
        bus.fs_idx = 5'd4;
        #1;
        n_checks++; if (bus.pc !== 32'h300) begin n_fail++; $display("FAIL jf_pc got %h want 300", bus.pc); end
        n_checks++; if (bus.fs_val !== 32'h3f800000) begin n_fail++; $display("FAIL jf_float got %h want 3f800000", bus.fs_val); end
        n_checks++; if (bus.instret !== exp_instret) begin n_fail++; $display("FAIL jal_instret got %h want %h", bus.instret, exp_instret); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hfffffffc;
        exp_pc[1] = 32'h0;
        exp_pc[2] = 32'h4;
        commit(3'b100, 5'd0, 32'h0, 32'hfffffffb);
        #1;
        n_checks++; if (bus.pc !== 32'hfffffff8) begin n_fail++; $display("FAIL b2b_start_pc got %h want fffffff8", bus.pc); end
        @(negedge clk);
        bus.enable    = 1'b1;
        bus.wselector = 3'b000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 2) bus.enable = 1'b0;
            exp_instret = exp_instret + 32'd1;
            n_checks++; if (bus.pc !== exp_pc[k]) begin n_fail++; $display("FAIL b2b_pc[%0d] got %h want %h", k, bus.pc, exp_pc[k]); end
            n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_done[%0d] got %b want 1", k, bus.done); end
        end
        n_checks++; if (bus.instret !== exp_instret) begin n_fail++; $display("FAIL b2b_instret got %h want %h", bus.instret, exp_instret); end
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_end got %b want 0", bus.done); end
        n_checks++; if (bus.pc !== 32'h4) begin n_fail++; $display("FAIL b2b_hold_pc got %h want 4", bus.pc); end
    endtask

    task automatic test_read_during_write();
        @(negedge clk);
        bus.rs_idx    = 5'd9;
        bus.enable    = 1'b1;
        bus.wselector = 3'b010;
        bus.rd        = 5'd9;
        bus.data      = 32'h1;
        #1;
        n_checks++; if (bus.rs_val !== 32'h0) begin n_fail++; $display("FAIL rdw_old got %h want 0", bus.rs_val); end
        @(negedge clk);
        bus.enable  = 1'b0;
        exp_instret = exp_instret + 32'd1;
        n_checks++; if (bus.rs_val !== 32'h1) begin n_fail++; $display("FAIL rdw_new got %h want 1", bus.rs_val); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] bad;
        commit(3'b010, 5'd12, 32'h12345678, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL mid_reset_pc got %h want 0", bus.pc); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_done got %b want 0", bus.done); end
        n_checks++; if (bus.instret !== 32'h0) begin n_fail++; $display("FAIL mid_reset_instret got %h want 0", bus.instret); end
        bad = 32'h0;
        for (int i = 0; i < 32; i++) begin
            bus.rs_idx = i[4:0];
            bus.fs_idx = i[4:0];
            #1;
            if (bus.rs_val !== 32'h0 || bus.fs_val !== 32'h0) bad[i] = 1'b1;
        end
        n_checks++; if (bad !== 32'h0) begin n_fail++; $display("FAIL mid_reset_regs got nonzero mask %h want 0", bad); end
        // Enable coincident with reset must not commit.
        bus.enable    = 1'b1;
        bus.wselector = 3'b110;
        bus.rd        = 5'd12;
        bus.data      = 32'hffff;
        bus.pc_target = 32'h80;
        @(negedge clk);
        bus.rs_idx = 5'd12;
        #1;
        n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL rst_enable_pc got %h want 0", bus.pc); end
        n_checks++; if (bus.rs_val !== 32'h0) begin n_fail++; $display("FAIL rst_enable_reg got %h want 0", bus.rs_val); end
        n_checks++; if (bus.instret !== 32'h0) begin n_fail++; $display("FAIL rst_enable_instret got %h want 0", bus.instret); end
        bus.enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_instret = 32'h0;
        commit(3'b000, 5'd0, 32'h0, 32'h0);
        #1;
        n_checks++; if (bus.pc !== 32'h4 || bus.instret !== 32'h1) begin n_fail++; $display("FAIL post_reset_commit got pc %h instret %h want 4 1", bus.pc, bus.instret); end
    endtask

    initial begin
        idle_inputs();
        exp_instret = 32'h0;
        #2;
        test_reset();
        test_alu();
        test_r0_f0();
        test_jal();
        test_back_to_back();
        test_read_during_write();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
